// File: rtl/divisor_frequencia_prog.sv
// divisor_frequencia_prog: runtime-programmable, fully synchronous frequency
// divider with NUM_CANAIS independent channels. Each channel produces a
// one-cycle clock-enable pulse (tick) every D enabled cycles and a 50% square
// wave (onda) that toggles on every tick. New divisors are written through a
// shadow register and only take effect on the channel's next wrap. This keeps
// the running period from being cut short.
// Optional feature: define DIVISOR_SYNC_EN to add the `sync` input. A pulse on
// `sync` realigns every channel and applies all pending divisors.
module divisor_frequencia_prog #(
    parameter int                            NUM_CANAIS = 3,
    parameter int                            WIDTH      = 28,
    parameter logic [NUM_CANAIS*WIDTH-1:0]   DIV_RESET  = {28'd8192, 28'd4194304, 28'd67108864}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CANAIS-1:0] enable,
    input  logic                  wr_en,
    input  logic [2:0]            wr_canal,
    input  logic [WIDTH-1:0]      wr_valor,
`ifdef DIVISOR_SYNC_EN
    input  logic                  sync,
`endif
    output logic                  wr_erro,
    output logic [NUM_CANAIS-1:0] pendente,
    output logic [NUM_CANAIS-1:0] tick,
    output logic [NUM_CANAIS-1:0] onda
);

    logic [WIDTH-1:0]      cnt    [NUM_CANAIS];
    logic [WIDTH-1:0]      div    [NUM_CANAIS];
    logic [WIDTH-1:0]      shadow [NUM_CANAIS];
    logic [NUM_CANAIS-1:0] wrap;
    logic [NUM_CANAIS-1:0] wr_sel;
    logic                  wr_ok;
    logic                  sync_i;

`ifdef DIVISOR_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // Decode the write request and detect which channels wrap on this edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        wr_sel = '0;
        wrap   = '0;
        wr_ok  = wr_en && (wr_valor != '0) && (int'(wr_canal) < NUM_CANAIS);
        for (int i = 0; i < NUM_CANAIS; i++) begin
            wr_sel[i] = wr_ok && (int'(wr_canal) == i);
            // div is never 0, so div-1 cannot underflow.
            wrap[i]   = enable[i] && (cnt[i] == div[i] - WIDTH'(1));
        end
    end

    // Per-channel counters, divisor/shadow registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: these register arrays are reset explicitly. div must come up holding DIV_RESET and not an unknown value.
            for (int i = 0; i < NUM_CANAIS; i++) begin
                cnt[i]    <= '0;
                div[i]    <= DIV_RESET[WIDTH*i +: WIDTH];
                shadow[i] <= '0;
            end
            pendente <= '0;
            tick     <= '0;
            onda     <= '0;
            wr_erro  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment. In each loop iteration the later write to pendente[i] overrides the earlier one.
            wr_erro <= wr_en && !wr_ok;
            for (int i = 0; i < NUM_CANAIS; i++) begin
                tick[i] <= 1'b0;
                if (sync_i) begin
                    // Realign: restart the count, clear the wave, apply any pending divisor.
                    cnt[i]      <= '0;
                    onda[i]     <= 1'b0;
                    pendente[i] <= 1'b0;
                    if (pendente[i]) begin
                        div[i] <= shadow[i];
                    end
                end else if (enable[i]) begin
                    if (wrap[i]) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
                        onda[i] <= ~onda[i];
                        if (pendente[i]) begin
                            div[i]      <= shadow[i];
                            pendente[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + WIDTH'(1);
                    end
                end else if (pendente[i]) begin
                    // An idle channel takes the new divisor at once. The count is kept only if it still fits.
                    div[i]      <= shadow[i];
                    pendente[i] <= 1'b0;
                    if (cnt[i] >= shadow[i]) begin
                        cnt[i] <= '0;
                    end
                end
                // A write this cycle lands after any wrap/sync apply and stays pending.
                if (wr_sel[i]) begin
                    shadow[i]   <= wr_valor;
                    pendente[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_divisor_frequencia_prog.sv
// Testbench for divisor_frequencia_prog (WIDTH=8, NUM_CANAIS=3, reset divisors {1,2,4}).
// A driver applies stimulus on the falling edge. It advances a behavioural model
// that tracks "edges remaining until the next tick" and the tick parity, and it
// pushes the expected outputs into a queue. A separate monitor pops one entry
// after each rising edge and compares it with the DUT.
// Define DIVISOR_SYNC_EN to exercise the sync input as well.
module tb_divisor_frequencia_prog;

    localparam int N = 3;
    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic [N-1:0] enable;
    logic         wr_en;
    logic [2:0]   wr_canal;
    logic [W-1:0] wr_valor;
    logic         sync_r;
    logic         wr_erro;
    logic [N-1:0] pendente;
    logic [N-1:0] tick;
    logic [N-1:0] onda;

    divisor_frequencia_prog #(
        .NUM_CANAIS (N),
        .WIDTH      (W),
        .DIV_RESET  ({8'd1, 8'd2, 8'd4})
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .wr_en    (wr_en),
        .wr_canal (wr_canal),
        .wr_valor (wr_valor),
`ifdef DIVISOR_SYNC_EN
        .sync     (sync_r),
`endif
        .wr_erro  (wr_erro),
        .pendente (pendente),
        .tick     (tick),
        .onda     (onda)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] v;   // {wr_erro, pendente, tick, onda}
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state per channel.
    int m_div    [N];
    int m_rem    [N];   // enabled edges left until the next tick
    int m_shadow [N];
    int m_ticks  [N];   // ticks since reset/sync; onda is its parity
    bit m_pend   [N];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {err,pend,tick,onda}=%b required %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        int init [N];
        init = '{4, 2, 1};
        for (int i = 0; i < N; i++) begin
            m_div[i]    = init[i];
            m_rem[i]    = init[i];
            m_shadow[i] = 0;
            m_ticks[i]  = 0;
            m_pend[i]   = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance the model over the next rising edge, and queue the expected outputs.
    task automatic step(input logic rst_v, input logic [2:0] en_v, input logic we,
                        input logic [2:0] ch, input logic [7:0] val, input logic sy,
                        input string tag);
        logic       ok;
        logic       sy_eff;
        logic [2:0] t;
        logic [9:0] e;
        int         el;
        exp_t       x;
        @(negedge clock);
        reset    = rst_v;
        enable   = en_v;
        wr_en    = we;
        wr_canal = ch;
        wr_valor = val;
`ifdef DIVISOR_SYNC_EN
        sync_r = sy;
        sy_eff = sy;
`else
        sync_r = 1'b0;
        sy_eff = 1'b0;
`endif
        t = '0;
        if (rst_v) begin
            model_reset();
            e = '0;
        end else begin
            ok = we && (val != 8'd0) && (ch < 3'd3);
            for (int i = 0; i < N; i++) begin
                if (sy_eff) begin
                    if (m_pend[i]) m_div[i] = m_shadow[i];
                    m_pend[i]  = 1'b0;
                    m_rem[i]   = m_div[i];
                    m_ticks[i] = 0;
                end else if (en_v[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        t[i] = 1'b1;
                        m_ticks[i]++;
                        if (m_pend[i]) begin
                            m_div[i]  = m_shadow[i];
                            m_pend[i] = 1'b0;
                        end
                        m_rem[i] = m_div[i];
                    end
                end else if (m_pend[i]) begin
                    el        = m_div[i] - m_rem[i];
                    m_div[i]  = m_shadow[i];
                    m_pend[i] = 1'b0;
                    m_rem[i]  = (el < m_div[i]) ? m_div[i] - el : m_div[i];
                end
                if (ok && int'(ch) == i) begin
                    m_shadow[i] = int'(val);
                    m_pend[i]   = 1'b1;
                end
            end
            e = {we && !ok, m_pend[2], m_pend[1], m_pend[0], t,
                 m_ticks[2][0], m_ticks[1][0], m_ticks[0][0]};
        end
        x.v   = e;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n, input logic [2:0] en_v, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, en_v, 1'b0, 3'd0, 8'd0, 1'b0, tag);
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t got;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check(got.tag, {wr_erro, pendente, tick, onda}, got.v);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        enable   = '0;
        wr_en    = 1'b0;
        wr_canal = '0;
        wr_valor = '0;
        sync_r   = 1'b0;
        model_reset();

        // Reset state, then free-running periods 4/2/1.
        step(1'b1, 3'b000, 1'b0, 3'd0, 8'd0, 1'b0, "reset");
        step(1'b1, 3'b000, 1'b0, 3'd0, 8'd0, 1'b0, "reset");
        idle(16, 3'b111, "run_default");

        // Write ch0=6 when cnt0==1; current period finishes, then period 6.
        for (int k = 0; k < 10 && (m_div[0] - m_rem[0]) != 1; k++) idle(1, 3'b111, "align_cnt1");
        step(1'b0, 3'b111, 1'b1, 3'd0, 8'd6, 1'b0, "wr_ch0_6");
        idle(20, 3'b111, "period6");

        // Rejected writes.
        step(1'b0, 3'b111, 1'b1, 3'd1, 8'd0, 1'b0, "wr_zero");
        idle(1, 3'b111, "after_wr_zero");
        step(1'b0, 3'b111, 1'b1, 3'd3, 8'd5, 1'b0, "wr_bad_canal");
        idle(8, 3'b111, "after_bad_canal");

        // Channel 1 paused for 5 cycles, then resumes.
        idle(5, 3'b101, "ch1_paused");
        idle(6, 3'b111, "ch1_resume");

        // Pending write, then a second write on the wrap edge of channel 0.
        step(1'b0, 3'b111, 1'b1, 3'd0, 8'd3, 1'b0, "wr_ch0_3");
        for (int k = 0; k < 10 && m_rem[0] != 1; k++) idle(1, 3'b111, "to_wrap");
        step(1'b0, 3'b111, 1'b1, 3'd0, 8'd5, 1'b0, "wr_on_wrap");
        idle(14, 3'b111, "after_wrap_write");

        // Idle channel with pending write applies immediately.
        step(1'b0, 3'b011, 1'b1, 3'd2, 8'd3, 1'b0, "wr_idle_ch2");
        idle(3, 3'b011, "ch2_idle_apply");
        idle(8, 3'b111, "ch2_new_div");

        // Reset mid-count with a pending write.
        step(1'b0, 3'b111, 1'b1, 3'd1, 8'd7, 1'b0, "wr_before_reset");
        step(1'b1, 3'b111, 1'b0, 3'd0, 8'd0, 1'b0, "mid_reset");
        step(1'b1, 3'b111, 1'b0, 3'd0, 8'd0, 1'b0, "mid_reset");
        idle(10, 3'b111, "after_reset");

`ifdef DIVISOR_SYNC_EN
        step(1'b0, 3'b111, 1'b1, 3'd0, 8'd5, 1'b0, "wr_before_sync");
        idle(1, 3'b111, "pre_sync");
        step(1'b0, 3'b111, 1'b1, 3'd1, 8'd3, 1'b1, "sync_with_write");
        idle(12, 3'b111, "after_sync");
`endif

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [2:0] en_r;
            logic       we_r;
            logic [2:0] ch_r;
            logic [7:0] val_r;
            logic       sy_r;
            logic       rst_r;
            en_r  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            we_r  = ($urandom_range(0, 2) == 0);
            ch_r  = 3'($urandom_range(0, 3));
            val_r = 8'($urandom_range(0, 7));
            sy_r  = ($urandom_range(0, 19) == 0);
            rst_r = ($urandom_range(0, 99) == 0);
            step(rst_r, en_r, we_r, ch_r, val_r, sy_r, "random");
        end

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
